// File: rtl/uart_ctrl_pkg.sv
// Shared types and helpers for the uart control blocks: FSM state encoding,
// byte width and a constant-foldable ceiling-log2.
package uart_ctrl_pkg;

    localparam int BYTE_W  = 8;
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE       = 2'd0,
        LOAD       = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < value) result = i + 1;
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: combinational one-hot winner at or after the pointer, wrapping.
// Pointer is registered and moves to winner+1 only on a qualified grant strobe.
module rr_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           grant_stb,
    output logic [N-1:0]   gnt_oh,
    output logic [IDW-1:0] gnt_idx,
    output logic           gnt_any
);

    logic [IDW-1:0] ptr_q, ptr_d;

    always_comb begin
        logic [IDW-1:0] j;
        j       = '0;
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = IDW'((int'(ptr_q) + i) % N);
            if (!gnt_any && req[j]) begin
                gnt_any    = 1'b1;
                gnt_oh[j]  = 1'b1;
                gnt_idx    = j;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_stb && gnt_any)
            ptr_d = (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + IDW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart transmitter among NUM_REQ producers; req sampled in cycle N gives ld/ack in N+1.
// Loads are paced on tx_empty: the next grant waits until the uart has shifted out the previous byte.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 16
) (
    input  logic                        txclk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*BYTE_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        ld_tx_data,
    output logic [BYTE_W-1:0]           tx_data,
    output logic                        tx_enable,
    input  logic                        tx_empty,
    output logic                        busy,
    output logic [clog2(NUM_REQ)-1:0]   grant_id,
    output logic                        err_timeout
);

    localparam int ID_W = clog2(NUM_REQ);
    localparam int TO_W = clog2(START_TIMEOUT + 1);

    state_e               state_q, state_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 ld_tx_data_q, ld_tx_data_d;
    logic [BYTE_W-1:0]    tx_data_q, tx_data_d;
    logic                 tx_enable_q, tx_enable_d;
    logic                 busy_q, busy_d;
    logic [ID_W-1:0]      grant_id_q, grant_id_d;
    logic                 err_timeout_q, err_timeout_d;

    logic [NUM_REQ-1:0]   gnt_oh;
    logic [ID_W-1:0]      gnt_idx;
    logic                 gnt_any;
    logic                 grant_go;
    logic                 timeout_hit;

    assign grant_go = (state_q == IDLE) && en && tx_empty && gnt_any;

    rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (ID_W)
    ) u_rr (
        .clk       (txclk),
        .rst       (reset),
        .req       (req),
        .grant_stb (grant_go),
        .gnt_oh    (gnt_oh),
        .gnt_idx   (gnt_idx),
        .gnt_any   (gnt_any)
    );

    always_ff @(posedge txclk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        to_cnt_d    = to_cnt_q;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE:       if (grant_go) state_d = LOAD;
            LOAD: begin
                state_d  = WAIT_START;
                to_cnt_d = '0;
            end
            // A uart that never acknowledges the load loses the byte; we do not retry it.
            WAIT_START: begin
                if (!tx_empty) begin
                    state_d = WAIT_DONE;
                end else if (to_cnt_q == TO_W'(START_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            WAIT_DONE:  if (tx_empty) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        ack_d         = '0;
        ld_tx_data_d  = 1'b0;
        tx_data_d     = tx_data_q;
        grant_id_d    = grant_id_q;
        err_timeout_d = err_timeout_q | timeout_hit;
        tx_enable_d   = en;
        busy_d        = (state_d != IDLE);
        if (grant_go) begin
            ld_tx_data_d = 1'b1;
            ack_d        = gnt_oh;
            grant_id_d   = gnt_idx;
            for (int i = 0; i < NUM_REQ; i++)
                if (gnt_oh[i]) tx_data_d = req_data[i*BYTE_W +: BYTE_W];
        end
    end

    always_ff @(posedge txclk or posedge reset) begin
        if (reset) begin
            ack_q         <= '0;
            ld_tx_data_q  <= 1'b0;
            tx_data_q     <= '0;
            tx_enable_q   <= 1'b0;
            busy_q        <= 1'b0;
            grant_id_q    <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            ack_q         <= ack_d;
            ld_tx_data_q  <= ld_tx_data_d;
            tx_data_q     <= tx_data_d;
            tx_enable_q   <= tx_enable_d;
            busy_q        <= busy_d;
            grant_id_q    <= grant_id_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign ack         = ack_q;
    assign ld_tx_data  = ld_tx_data_q;
    assign tx_data     = tx_data_q;
    assign tx_enable   = tx_enable_q;
    assign busy        = busy_q;
    assign grant_id    = grant_id_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: reset-state vectors, directed corner sequences and
// randomized traffic checked against a round-robin scoreboard and a simple uart model.
module tb_uart_tx_arbiter;

    localparam int N        = 4;
    localparam int U_NORMAL = 0;
    localparam int U_IGNORE = 1;
    localparam int U_FORCE  = 2;
    localparam int P_MANUAL = 0;
    localparam int P_DROP   = 1;
    localparam int P_KEEP   = 2;

    logic          txclk = 1'b0;
    logic          reset;
    logic          en;
    logic [N-1:0]  req;
    logic [N*8-1:0] req_data;
    logic [N-1:0]  ack;
    logic          ld_tx_data;
    logic [7:0]    tx_data;
    logic          tx_enable;
    logic          tx_empty;
    logic          busy;
    logic [1:0]    grant_id;
    logic          err_timeout;

    int   n_checks = 0;
    int   n_errors = 0;
    int   uart_mode;
    int   busy_cnt;
    int   frame_len;
    logic ld_prev;
    int   policy;
    int   rr_ptr;
    int   ack_log[$];

    typedef struct {
        logic [3:0]  rq;
        logic [31:0] rd;
        logic [3:0]  e_ack;
        logic [1:0]  e_gid;
        logic [7:0]  e_dat;
    } vec_t;

    vec_t vt [6];

    always #5 txclk = ~txclk;

    uart_tx_arbiter #(
        .NUM_REQ       (N),
        .START_TIMEOUT (16)
    ) dut (
        .txclk       (txclk),
        .reset       (reset),
        .en          (en),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .ld_tx_data  (ld_tx_data),
        .tx_data     (tx_data),
        .tx_enable   (tx_enable),
        .tx_empty    (tx_empty),
        .busy        (busy),
        .grant_id    (grant_id),
        .err_timeout (err_timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (p + k) % N;
            if (r[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    // Inputs present at the moment of the check are the ones the DUT sampled on this edge.
    task automatic step();
        int w;
        @(posedge txclk);
        #1;
        chk("ld_eq_ack", ld_tx_data, |ack);
        chk("tx_enable_lag", tx_enable, en);
        if (ack != '0) begin
            chk("ack_has_req", (req != '0), 1);
            chk("grant_en", en, 1);
            chk("grant_empty", tx_empty, 1);
            w = rr_pick(req, rr_ptr);
            if (w >= 0) begin
                chk("ack_rr", ack, 32'(1 << w));
                chk("grant_id", grant_id, w);
                chk("tx_data", tx_data, req_data[8*w +: 8]);
                rr_ptr = (w + 1) % N;
                ack_log.push_back(w);
                if (policy == P_DROP)      req[w] = 1'b0;
                else if (policy == P_KEEP) req_data[8*w +: 8] = 8'($urandom);
            end
        end
        if (uart_mode == U_NORMAL) begin
            if (ld_prev)           busy_cnt = frame_len;
            else if (busy_cnt > 0) busy_cnt--;
            tx_empty = (busy_cnt == 0);
        end else begin
            tx_empty = (uart_mode == U_IGNORE);
        end
        ld_prev = ld_tx_data;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ack"},      ack, 0);
        chk({tag, "_ld"},       ld_tx_data, 0);
        chk({tag, "_tx_data"},  tx_data, 0);
        chk({tag, "_tx_en"},    tx_enable, 0);
        chk({tag, "_busy"},     busy, 0);
        chk({tag, "_grant_id"}, grant_id, 0);
        chk({tag, "_err"},      err_timeout, 0);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req       = '0;
        en        = 1'b1;
        uart_mode = U_NORMAL;
        busy_cnt  = 0;
        frame_len = 10;
        tx_empty  = 1'b1;
        ld_prev   = 1'b0;
        rr_ptr    = 0;
        policy    = P_MANUAL;
        ack_log.delete();
        repeat (2) @(posedge txclk);
        @(negedge txclk);
        reset = 1'b0;
        step();
    endtask

    task automatic wait_acks(input int n, input int budget, input string name);
        int t;
        t = 0;
        while (ack_log.size() < n && t < budget) begin
            step();
            t++;
        end
        chk({name, "_acks"}, ack_log.size(), n);
    endtask

    initial begin
        int t;
        int n_ld;
        logic [1:0] r;

        vt[0] = '{4'b0100, 32'h11A53344, 4'b0100, 2'd2, 8'hA5};
        vt[1] = '{4'b0001, 32'hDEADBEEF, 4'b0001, 2'd0, 8'hEF};
        vt[2] = '{4'b1000, 32'hDEADBEEF, 4'b1000, 2'd3, 8'hDE};
        vt[3] = '{4'b1010, 32'h12345678, 4'b0010, 2'd1, 8'h56};
        vt[4] = '{4'b1111, 32'hCAFEF00D, 4'b0001, 2'd0, 8'h0D};
        vt[5] = '{4'b0110, 32'h0F1E2D3C, 4'b0010, 2'd1, 8'h2D};

        reset = 1'b0; en = 1'b0; req = '0; req_data = '0; tx_empty = 1'b1;
        uart_mode = U_NORMAL; busy_cnt = 0; frame_len = 10; ld_prev = 1'b0;
        policy = P_MANUAL; rr_ptr = 0;
        #2 reset = 1'b1;
        #1 check_reset("por");

        for (int i = 0; i < 6; i++) begin
            do_reset();
            req      = vt[i].rq;
            req_data = vt[i].rd;
            step();
            chk($sformatf("vec%0d_ld", i),   ld_tx_data, 1);
            chk($sformatf("vec%0d_ack", i),  ack, vt[i].e_ack);
            chk($sformatf("vec%0d_gid", i),  grant_id, vt[i].e_gid);
            chk($sformatf("vec%0d_data", i), tx_data, vt[i].e_dat);
            chk($sformatf("vec%0d_busy", i), busy, 1);
            req = '0;
        end

        // All requesters held high: strict rotation, fresh data per byte.
        do_reset();
        policy   = P_KEEP;
        req_data = $urandom;
        req      = 4'hF;
        wait_acks(5, 300, "rot");
        for (int i = 0; i < 5; i++)
            if (i < ack_log.size()) chk($sformatf("rot_order%0d", i), ack_log[i], i % N);
        req = '0;
        policy = P_MANUAL;

        // Uart never starts: timeout after the load, byte not re-acked.
        do_reset();
        uart_mode = U_IGNORE;
        policy    = P_DROP;
        req_data  = 32'h00005A66;
        req       = 4'b0001;
        t = 0;
        while (!ld_tx_data && t < 20) begin step(); t++; end
        chk("to_load", ld_tx_data, 1);
        repeat (15) step();
        chk("to_err_early", err_timeout, 0);
        chk("to_busy_wait", busy, 1);
        t = 0;
        while (!err_timeout && t < 5) begin step(); t++; end
        chk("to_err", err_timeout, 1);
        chk("to_idle", busy, 0);
        chk("to_single_ack", ack_log.size(), 1);
        uart_mode = U_NORMAL;
        req       = 4'b0010;
        wait_acks(2, 50, "to_next");
        chk("to_next_gid", grant_id, 1);
        chk("to_sticky", err_timeout, 1);

        // Async reset in the middle of WAIT_DONE with the error flag already set.
        repeat (4) step();
        chk("wd_busy", busy, 1);
        chk("wd_uart_busy", tx_empty, 0);
        #3 reset = 1'b1;
        #1 check_reset("mid");

        // en falls while a byte is in flight.
        do_reset();
        policy   = P_DROP;
        req_data = 32'h0000C3A7;
        req      = 4'b0011;
        wait_acks(1, 20, "en_first");
        repeat (3) step();
        chk("en_in_flight", busy, 1);
        chk("en_txen_before", tx_enable, 1);
        en = 1'b0;
        step();
        chk("en_txen_after", tx_enable, 0);
        n_ld = 0;
        repeat (30) begin step(); if (ld_tx_data) n_ld++; end
        chk("en_no_load", n_ld, 0);
        chk("en_byte_done", busy, 0);
        chk("en_pending", req, 4'b0010);
        en = 1'b1;
        step();
        chk("en_txen_back", tx_enable, 1);
        chk("en_regrant", ld_tx_data, 1);
        chk("en_second", ack_log.size(), 2);

        // Uart busy from elsewhere: no grant until tx_empty rises.
        do_reset();
        policy    = P_DROP;
        uart_mode = U_FORCE;
        tx_empty  = 1'b0;
        req_data  = 32'h00000077;
        req       = 4'b0001;
        n_ld = 0;
        repeat (20) begin step(); if (ld_tx_data || ack != '0) n_ld++; end
        chk("hold_no_load", n_ld, 0);
        chk("hold_idle", busy, 0);
        uart_mode = U_NORMAL;
        step();
        chk("rise_not_yet", ld_tx_data, 0);
        step();
        chk("rise_grant", ld_tx_data, 1);
        chk("rise_ack", ack, 4'b0001);
        chk("rise_data", tx_data, 8'h77);

        // Randomized traffic against the scoreboard, then drain.
        do_reset();
        policy = P_DROP;
        for (int c = 0; c < 3000; c++) begin
            frame_len = $urandom_range(2, 12);
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) begin
                r = 2'($urandom_range(0, N - 1));
                if (!req[r]) begin
                    req[r] = 1'b1;
                    req_data[8*r +: 8] = 8'($urandom);
                end
            end
            step();
        end
        en = 1'b1;
        t = 0;
        while (req != '0 && t < 400) begin step(); t++; end
        chk("rand_drain", req, 0);
        chk("rand_traffic", (ack_log.size() > 50), 1);
        chk("rand_no_timeout", err_timeout, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1);
    end

endmodule
